// File: rtl/cla_seq_ctrl_if.sv
// Request/response bundle for the nibble-serial CLA sequencer: two requester
// ports and one result port, with the arbiter/sequencer on the slave side.
interface cla_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/cla_seq_ctrl.sv
// Round-robin arbiter and nibble-serial sequencer that shares one external
// 4-bit CLA slice between two requesters, carrying between nibbles in a register.
module cla_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  cla_seq_ctrl_if.slave bus,
  output logic [3:0] cla_a,
  output logic [3:0] cla_b,
  output logic       cla_cin,
  input  logic [3:0] cla_s,
  input  logic [4:0] cla_c,
  output logic [1:0] state_dbg
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [NIB-1:0][3:0]  a_reg, b_reg, sum_reg;
  logic [IDXW-1:0]      idx;
  logic                 carry;
  logic                 cout_reg;
  logic                 id_reg;
  logic                 last_id;
  logic                 any_valid;
  logic                 gnt_id;
  logic                 accept;
  logic                 last_step;
  logic                 unused_carry_bits;

  assign unused_carry_bits = ^cla_c[3:0];

  // Handshakes: a transfer happens in a cycle where valid && ready are both
  // high; ready never depends on anything but state, rst and the valids.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign gnt_id    = (bus.req0_valid && bus.req1_valid) ? ~last_id : bus.req1_valid;
  assign accept    = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
  assign last_step = (idx == IDXW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n        = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    cla_a          = 4'h0;
    cla_b          = 4'h0;
    cla_cin        = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && any_valid) begin
          bus.req0_ready = ~gnt_id;
          bus.req1_ready = gnt_id;
          state_n        = RUN;
        end
      end
      RUN: begin
        cla_a   = a_reg[idx];
        cla_b   = b_reg[idx];
        cla_cin = carry;
        if (last_step) state_n = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      id_reg   <= 1'b0;
      last_id  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg   <= gnt_id ? bus.req1_a : bus.req0_a;
            b_reg   <= gnt_id ? bus.req1_b : bus.req0_b;
            carry   <= gnt_id ? bus.req1_cin : bus.req0_cin;
            id_reg  <= gnt_id;
            last_id <= gnt_id;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_reg[idx] <= cla_s;
          carry        <= cla_c[4];
          if (last_step) begin
            cout_reg <= cla_c[4];
            idx      <= '0;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_sum   = sum_reg;
  assign bus.rsp_cout  = cout_reg;
  assign bus.rsp_id    = id_reg;
  assign state_dbg     = state;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl with a behavioural 4-bit CLA slice attached.
module tb_cla_seq_ctrl;
  localparam int WIDTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cla_a, cla_b, cla_s;
  logic       cla_cin;
  logic [4:0] cla_c;
  logic [1:0] state_dbg;
  int tests_run = 0;
  int tests_failed = 0;

  cla_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_s(cla_s), .cla_c(cla_c), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Bit-level carry chain standing in for the shared slice.
  always_comb begin
    cla_c    = '0;
    cla_s    = '0;
    cla_c[0] = cla_cin;
    for (int i = 0; i < 4; i++) begin
      cla_s[i]   = cla_a[i] ^ cla_b[i] ^ cla_c[i];
      cla_c[i+1] = (cla_a[i] & cla_b[i]) | (cla_c[i] & (cla_a[i] ^ cla_b[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic offer(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    tick(); tick(); #1;
    tests_run++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin tests_failed++; $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready}); end
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    tests_run++; if ({bus.rsp_sum, bus.rsp_cout, bus.rsp_id} !== 18'h0) begin tests_failed++; $display("FAIL reset_rsp_fields: got %h expected 0", {bus.rsp_sum, bus.rsp_cout, bus.rsp_id}); end
    tests_run++; if ({cla_a, cla_b, cla_cin} !== 9'h0) begin tests_failed++; $display("FAIL reset_cla: got %h expected 0", {cla_a, cla_b, cla_cin}); end
    tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] exp_a [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    tick();
    offer(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    #1;
    tests_run++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL basic_grant: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.req0_valid = 1'b0;
      bus.req0_a = 16'hDEAD;
      #1;
      tests_run++; if (cla_a !== exp_a[i]) begin tests_failed++; $display("FAIL basic_cla_a[%0d]: got %h expected %h", i, cla_a, exp_a[i]); end
      tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid[%0d]: got %b expected 0", i, bus.rsp_valid); end
    end
    tick(); #1;
    tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_latency: rsp_valid got %b expected 1", bus.rsp_valid); end
    tests_run++; if (bus.rsp_sum !== 16'h2233) begin tests_failed++; $display("FAIL basic_sum: got %h expected 2233", bus.rsp_sum); end
    tests_run++; if ({bus.rsp_cout, bus.rsp_id} !== 2'b00) begin tests_failed++; $display("FAIL basic_cout_id: got %b expected 00", {bus.rsp_cout, bus.rsp_id}); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_drop: got %b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_ripple();
    tick();
    offer(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    #1;
    tests_run++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin tests_failed++; $display("FAIL ripple_grant: got %b expected 01", {bus.req0_ready, bus.req1_ready}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.req1_valid = 1'b0;
      #1;
      tests_run++; if (cla_cin !== 1'b1) begin tests_failed++; $display("FAIL ripple_cin[%0d]: got %b expected 1", i, cla_cin); end
    end
    tick(); #1;
    tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL ripple_latency: rsp_valid got %b expected 1", bus.rsp_valid); end
    tests_run++; if ({bus.rsp_sum, bus.rsp_cout, bus.rsp_id} !== {16'h0000, 1'b1, 1'b1}) begin tests_failed++; $display("FAIL ripple_result: got %h expected %h", {bus.rsp_sum, bus.rsp_cout, bus.rsp_id}, {16'h0000, 1'b1, 1'b1}); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int n = 0;
    tick();
    offer(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    #1;
    tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL overflow_grant: got %b expected 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 1'b0;
    #1;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin tick(); #1; n++; end
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL overflow_latency: got %0d expected 4", n); end
    tests_run++; if ({bus.rsp_sum, bus.rsp_cout, bus.rsp_id} !== {16'hFFFF, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL overflow_result: got %h expected %h", {bus.rsp_sum, bus.rsp_cout, bus.rsp_id}, {16'hFFFF, 1'b1, 1'b0}); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_gnt [$];
    logic g;
    int accepts = 0;
    int rsps = 0;
    int last_acc = -1;
    int cyc = 0;
    tick();
    rst = 1'b1;
    offer(1'b0, 16'h0101, 16'h0202, 1'b0);
    offer(1'b1, 16'h8000, 16'h8000, 1'b1);
    bus.rsp_ready = 1'b1;
    #1;
    tests_run++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin tests_failed++; $display("FAIL b2b_ready_in_rst: got %b expected 00", {bus.req0_ready, bus.req1_ready}); end
    tick();
    rst = 1'b0;
    while (rsps < 4 && cyc < 60) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        g = bus.req1_ready;
        tests_run++; if (bus.req0_ready && bus.req1_ready) begin tests_failed++; $display("FAIL b2b_onehot: got 11 expected one ready"); end
        tests_run++; if (g !== (accepts % 2 == 1)) begin tests_failed++; $display("FAIL b2b_order[%0d]: got %b expected %b", accepts, g, (accepts % 2 == 1)); end
        if (last_acc >= 0) begin
          tests_run++; if (cyc - last_acc !== 6) begin tests_failed++; $display("FAIL b2b_period[%0d]: got %0d expected 6", accepts, cyc - last_acc); end
        end
        exp_gnt.push_back(g);
        accepts++;
        last_acc = cyc;
      end
      if (bus.rsp_valid === 1'b1) begin
        g = (exp_gnt.size() > 0) ? exp_gnt.pop_front() : 1'bx;
        tests_run++; if (bus.rsp_id !== g) begin tests_failed++; $display("FAIL b2b_rsp_id[%0d]: got %b expected %b", rsps, bus.rsp_id, g); end
        tests_run++; if ({bus.rsp_sum, bus.rsp_cout} !== (g ? {16'h0001, 1'b1} : {16'h0303, 1'b0})) begin tests_failed++; $display("FAIL b2b_rsp_sum[%0d]: got %h expected %h", rsps, {bus.rsp_sum, bus.rsp_cout}, (g ? {16'h0001, 1'b1} : {16'h0303, 1'b0})); end
        rsps++;
      end
      if (rsps < 4) begin tick(); cyc++; end
    end
    tests_run++; if (rsps !== 4) begin tests_failed++; $display("FAIL b2b_timeout: got %0d responses expected 4", rsps); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n = 0;
    tick();
    offer(1'b0, 16'h00FF, 16'h0001, 1'b0);
    #1;
    tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_grant: got %b expected 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 1'b0;
    offer(1'b1, 16'h0010, 16'h0020, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin tick(); #1; end
      tests_run++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin tests_failed++; $display("FAIL bp_run_ready[%0d]: got %b expected 00", i, {bus.req0_ready, bus.req1_ready}); end
    end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      tests_run++; if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_id} !== {1'b1, 16'h0100, 1'b0}) begin tests_failed++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, {bus.rsp_valid, bus.rsp_sum, bus.rsp_id}, {1'b1, 16'h0100, 1'b0}); end
      tests_run++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin tests_failed++; $display("FAIL bp_done_ready[%0d]: got %b expected 00", i, {bus.req0_ready, bus.req1_ready}); end
    end
    tick();
    bus.rsp_ready = 1'b1;
    #1;
    tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_rsp_hs: got %b expected 1", bus.rsp_valid); end
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    tests_run++; if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b001) begin tests_failed++; $display("FAIL bp_next_accept: got %b expected 001", {bus.rsp_valid, bus.req0_ready, bus.req1_ready}); end
    tick();
    bus.req1_valid = 1'b0;
    #1;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin tick(); #1; n++; end
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL bp_second_latency: got %0d expected 4", n); end
    tests_run++; if ({bus.rsp_sum, bus.rsp_id} !== {16'h0030, 1'b1}) begin tests_failed++; $display("FAIL bp_second_result: got %h expected %h", {bus.rsp_sum, bus.rsp_id}, {16'h0030, 1'b1}); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    tick();
    offer(1'b0, 16'h1111, 16'h2222, 1'b0);
    #1;
    tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_grant: got %b expected 1", bus.req0_ready); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests_run++; if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id} !== 19'h0) begin tests_failed++; $display("FAIL midrst_rsp_cleared: got %h expected 0", {bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id}); end
    tests_run++; if ({cla_a, cla_b, cla_cin} !== 9'h0) begin tests_failed++; $display("FAIL midrst_cla_cleared: got %h expected 0", {cla_a, cla_b, cla_cin}); end
    tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL midrst_state: got %0d expected 0", state_dbg); end
    tests_run++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL midrst_reaccept: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
    tick();
    bus.req0_valid = 1'b0;
    #1;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin tick(); #1; n++; end
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL midrst_latency: got %0d expected 4", n); end
    tests_run++; if ({bus.rsp_sum, bus.rsp_cout, bus.rsp_id} !== {16'h3333, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL midrst_result: got %h expected %h", {bus.rsp_sum, bus.rsp_cout, bus.rsp_id}, {16'h3333, 1'b0, 1'b0}); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_ripple();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule
